// File: rtl/sparse_ptr_pingpong_buffer_if.sv
// ---------------------------------------------------------------------------
// sparse_ptr_pingpong_buffer_if : count-stream and reader bus of the pointer store
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sparse_ptr_pingpong_buffer_if #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 17,
  parameter int AWIDTH = 5
);
  logic                     cnt_valid;
  logic                     cnt_ready;
  logic [DWIDTH-1:0]        cnt_data;
  logic                     rd_valid;
  logic                     rd_release;
  logic [DWIDTH*DEPTH-1:0]  q_all;
  logic                     rd_ce;
  logic [AWIDTH-1:0]        rd_addr;
  logic [DWIDTH-1:0]        q1;
  logic                     ovf;

  modport master (
    output cnt_valid, cnt_data, rd_release, rd_ce, rd_addr,
    input  cnt_ready, rd_valid, q_all, q1, ovf
  );

  modport slave (
    input  cnt_valid, cnt_data, rd_release, rd_ce, rd_addr,
    output cnt_ready, rd_valid, q_all, q1, ovf
  );
endinterface

`default_nettype wire

// File: rtl/sparse_ptr_pingpong_buffer.sv
// ---------------------------------------------------------------------------
// sparse_ptr_pingpong_buffer : double-buffered CSR row-pointer builder.
// Macro PTR_SAT_EN selects saturating sums (default: wrap). Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sparse_ptr_pingpong_buffer #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 17,
  parameter int AWIDTH = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  sparse_ptr_pingpong_buffer_if.slave   bus
);

  localparam int              IW       = $clog2(DEPTH);
  localparam logic [IW-1:0]   LAST_IDX = IW'(DEPTH - 2);
  localparam logic [AWIDTH:0] DEPTH_A  = DEPTH[AWIDTH:0];

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]              state;
  logic [0:0]              state_nxt;

  // Entry 0 of each bank is never used: ptr[0] is the constant zero.
  logic [DWIDTH-1:0]       bank [2][DEPTH];

  logic                    wr_sel;
  logic                    rd_sel;
  logic [IW-1:0]           idx;
  logic [DWIDTH-1:0]       acc;
  logic                    ovf_w;
  logic                    accept;
  logic                    swap;
  logic                    rd_hit;
  logic [DWIDTH:0]         sum_raw;
  logic [DWIDTH-1:0]       sum;
  logic [DWIDTH*DEPTH-1:0] q_all_nxt;

  assign rd_sel  = ~wr_sel;
  assign sum_raw = {1'b0, acc} + {1'b0, bus.cnt_data};

`ifdef PTR_SAT_EN
  // Once clamped, acc stays at all-ones so every later pointer stays clamped.
  assign sum = sum_raw[DWIDTH] ? {DWIDTH{1'b1}} : sum_raw[DWIDTH-1:0];
`else
  assign sum = sum_raw[DWIDTH-1:0];
`endif

  assign rd_hit = (bus.rd_addr != '0) && ({1'b0, bus.rd_addr} < DEPTH_A);

  assign q_all_nxt[DWIDTH*DEPTH-1 -: DWIDTH] = '0;
  for (genvar i = 1; i < DEPTH; i++) begin : g_qall
    assign q_all_nxt[DWIDTH*(DEPTH-1-i) +: DWIDTH] = bank[wr_sel][i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL:  if (bus.cnt_valid && (idx == LAST_IDX)) state_nxt = S_HOLD;
      S_HOLD:  if (!bus.rd_valid || bus.rd_release)    state_nxt = S_FILL;
      default: state_nxt = S_FILL;
    endcase
  end

  always_comb begin
    bus.cnt_ready = 1'b0;
    accept        = 1'b0;
    swap          = 1'b0;
    case (state)
      S_FILL: begin
        bus.cnt_ready = 1'b1;
        accept        = bus.cnt_valid;
      end
      S_HOLD:  swap = !bus.rd_valid || bus.rd_release;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) bank[wr_sel][idx + 1'b1] <= sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel       <= 1'b0;
      idx          <= '0;
      acc          <= '0;
      ovf_w        <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.q_all    <= '0;
      bus.ovf      <= 1'b0;
      bus.q1       <= '0;
    end else begin
      if (swap) begin
        wr_sel       <= ~wr_sel;
        idx          <= '0;
        acc          <= '0;
        ovf_w        <= 1'b0;
        bus.rd_valid <= 1'b1;
        bus.q_all    <= q_all_nxt;
        bus.ovf      <= ovf_w;
      end else begin
        if (accept) begin
          acc <= sum;
          idx <= idx + 1'b1;
          if (sum_raw[DWIDTH]) ovf_w <= 1'b1;
        end
        if (bus.rd_release && bus.rd_valid) bus.rd_valid <= 1'b0;
      end
      // Uses the pre-swap rd_sel, so a read on the swap edge sees the old bank.
      if (bus.rd_ce && bus.rd_valid)
        bus.q1 <= rd_hit ? bank[rd_sel][bus.rd_addr[IW-1:0]] : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sparse_ptr_pingpong_buffer.sv
// ---------------------------------------------------------------------------
// tb_sparse_ptr_pingpong_buffer : directed self-checking bench, DEPTH=5 DWIDTH=8
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sparse_ptr_pingpong_buffer;
  localparam int DW = 8;
  localparam int DP = 5;
  localparam int AW = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sparse_ptr_pingpong_buffer_if #(.DWIDTH(DW), .DEPTH(DP), .AWIDTH(AW)) bus ();

  sparse_ptr_pingpong_buffer #(.DWIDTH(DW), .DEPTH(DP), .AWIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] cnts;
    logic [39:0] q;
    logic        ovf;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] pk(input logic [7:0] a, b, c, d, e);
    return {a, b, c, d, e};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] cnts);
    for (int k = 0; k < 4; k++) begin
      check("fill_ready", 64'(bus.cnt_ready), 64'd1);
      bus.cnt_valid = 1'b1;
      bus.cnt_data  = cnts[31-8*k -: 8];
      step();
    end
    bus.cnt_valid = 1'b0;
  endtask

  task automatic release_pulse();
    bus.rd_release = 1'b1;
    step();
    bus.rd_release = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{cnts: {8'd3, 8'd0, 8'd2, 8'd5}, q: pk(0, 3, 3, 5, 10), ovf: 1'b0};
    vecs[3] = '{cnts: {8'd1, 8'd2, 8'd3, 8'd4}, q: pk(0, 1, 3, 6, 10), ovf: 1'b0};
    vecs[4] = '{cnts: {8'd0, 8'd0, 8'd0, 8'd0}, q: pk(0, 0, 0, 0, 0),  ovf: 1'b0};
`ifdef PTR_SAT_EN
    vecs[1] = '{cnts: {8'd200, 8'd100, 8'd1, 8'd1}, q: pk(0, 200, 255, 255, 255), ovf: 1'b1};
    vecs[2] = '{cnts: {8'd255, 8'd0, 8'd0, 8'd1},   q: pk(0, 255, 255, 255, 255), ovf: 1'b1};
    vecs[5] = '{cnts: {8'd128, 8'd128, 8'd0, 8'd0}, q: pk(0, 128, 255, 255, 255), ovf: 1'b1};
`else
    vecs[1] = '{cnts: {8'd200, 8'd100, 8'd1, 8'd1}, q: pk(0, 200, 44, 45, 46),    ovf: 1'b1};
    vecs[2] = '{cnts: {8'd255, 8'd0, 8'd0, 8'd1},   q: pk(0, 255, 255, 255, 0),   ovf: 1'b1};
    vecs[5] = '{cnts: {8'd128, 8'd128, 8'd0, 8'd0}, q: pk(0, 128, 0, 0, 0),       ovf: 1'b1};
`endif

    bus.cnt_valid  = 1'b0;
    bus.cnt_data   = '0;
    bus.rd_release = 1'b0;
    bus.rd_ce      = 1'b0;
    bus.rd_addr    = '0;

    step();
    step();
    check("rst_cnt_ready", 64'(bus.cnt_ready), 64'd1);
    check("rst_rd_valid",  64'(bus.rd_valid),  64'd0);
    check("rst_q_all",     64'(bus.q_all),     64'd0);
    check("rst_q1",        64'(bus.q1),        64'd0);
    check("rst_ovf",       64'(bus.ovf),       64'd0);
    rst_n = 1'b1;
    step();

    // Fill and immediate swap for each table entry
    for (int i = 0; i < 6; i++) begin
      if (i != 0) begin
        release_pulse();
        check("vec_released", 64'(bus.rd_valid), 64'd0);
      end
      fill(vecs[i].cnts);
      step();
      check("vec_rd_valid", 64'(bus.rd_valid), 64'd1);
      check("vec_q_all",    64'(bus.q_all),    64'(vecs[i].q));
      check("vec_ovf",      64'(bus.ovf),      64'(vecs[i].ovf));
    end

    // Random reads on bank {0,3,3,5,10}
    release_pulse();
    fill({8'd3, 8'd0, 8'd2, 8'd5});
    step();
    check("rr_q_all", 64'(bus.q_all), 64'(pk(0, 3, 3, 5, 10)));
    bus.rd_ce = 1'b1;
    bus.rd_addr = 3'd3; step(); check("rr_addr3", 64'(bus.q1), 64'd5);
    bus.rd_addr = 3'd0; step(); check("rr_addr0", 64'(bus.q1), 64'd0);
    bus.rd_addr = 3'd4; step(); check("rr_addr4", 64'(bus.q1), 64'd10);
    bus.rd_addr = 3'd7; step(); check("rr_addr7", 64'(bus.q1), 64'd0);
    bus.rd_addr = 3'd1; step(); check("rr_addr1", 64'(bus.q1), 64'd3);
    bus.rd_ce = 1'b0;
    bus.rd_addr = 3'd4; step(); check("rr_hold",  64'(bus.q1), 64'd3);

    // Fill while reader holds the bank, then release three cycles later
    fill({8'd1, 8'd1, 8'd1, 8'd1});
    step();
    check("hold_ready",  64'(bus.cnt_ready), 64'd0);
    check("hold_q_all",  64'(bus.q_all),     64'(pk(0, 3, 3, 5, 10)));
    step();
    step();
    check("hold_rd_valid", 64'(bus.rd_valid), 64'd1);
    bus.rd_release = 1'b1;
    bus.rd_ce      = 1'b1;
    bus.rd_addr    = 3'd4;
    step();
    bus.rd_release = 1'b0;
    bus.rd_ce      = 1'b0;
    check("swap_q_all",    64'(bus.q_all),     64'(pk(0, 1, 2, 3, 4)));
    check("swap_rd_valid", 64'(bus.rd_valid),  64'd1);
    check("swap_q1_old",   64'(bus.q1),        64'd10);
    check("swap_ready",    64'(bus.cnt_ready), 64'd1);

    // Release with no pending bank: stale data, rd_valid low, reads ignored
    release_pulse();
    check("rel_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("rel_q_all",    64'(bus.q_all),    64'(pk(0, 1, 2, 3, 4)));
    bus.rd_ce   = 1'b1;
    bus.rd_addr = 3'd2;
    step();
    bus.rd_ce   = 1'b0;
    check("rel_q1_hold", 64'(bus.q1), 64'd10);

    // Reset after two accepts discards the partial fill
    bus.cnt_valid = 1'b1;
    bus.cnt_data  = 8'd7;
    step();
    step();
    bus.cnt_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_ready",    64'(bus.cnt_ready), 64'd1);
    check("mrst_rd_valid", 64'(bus.rd_valid),  64'd0);
    check("mrst_q_all",    64'(bus.q_all),     64'd0);
    check("mrst_ovf",      64'(bus.ovf),       64'd0);
    check("mrst_q1",       64'(bus.q1),        64'd0);
    step();
    rst_n = 1'b1;
    step();
    fill({8'd4, 8'd4, 8'd4, 8'd4});
    step();
    check("mrst_fill_valid", 64'(bus.rd_valid), 64'd1);
    check("mrst_fill_q_all", 64'(bus.q_all),    64'(pk(0, 4, 8, 12, 16)));

    // cnt_valid held through HOLD: the held count is taken once after the swap
    fill({8'd2, 8'd2, 8'd2, 8'd2});
    bus.cnt_valid = 1'b1;
    bus.cnt_data  = 8'd9;
    step();
    step();
    step();
    check("held_ready", 64'(bus.cnt_ready), 64'd0);
    release_pulse();
    check("held_swap_q_all", 64'(bus.q_all),     64'(pk(0, 2, 4, 6, 8)));
    check("held_swap_ready", 64'(bus.cnt_ready), 64'd1);
    step();
    bus.cnt_data = 8'd1;
    step();
    step();
    step();
    bus.cnt_valid = 1'b0;
    step();
    check("held_full_ready", 64'(bus.cnt_ready), 64'd0);
    release_pulse();
    check("held_q_all", 64'(bus.q_all), 64'(pk(0, 9, 10, 11, 12)));
    check("held_ovf",   64'(bus.ovf),   64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
